// File: rtl/set_job_dispatcher.sv
// Job dispatcher for the SET circle-counting engine.
// Buffers host jobs in a small FIFO, issues them to the engine one at a time,
// and returns each job's candidate count (or a timeout error) with its tag.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. The producer holds valid and its payload stable until that edge.
// in_ready depends only on the registered FIFO count. out_valid is registered
// and does not depend on out_ready.
module set_job_dispatcher #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [23:0]              in_central,
  input  logic [11:0]              in_radius,
  input  logic [1:0]               in_mode,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     set_en,
  output logic [23:0]              set_central,
  output logic [11:0]              set_radius,
  output logic [1:0]               set_mode,
  input  logic                     set_busy,
  input  logic                     set_valid,
  input  logic [7:0]               set_candidate,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TAG_W-1:0]         out_tag,
  output logic [7:0]               out_candidate,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [1:0]               dbg_state
);

  localparam int AW  = $clog2(DEPTH);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [AW:0]    FULL    = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state;

  // Job storage, one array per field
  logic [23:0]      central_mem [DEPTH];
  logic [11:0]      radius_mem  [DEPTH];
  logic [1:0]       mode_mem    [DEPTH];
  logic [TAG_W-1:0] tag_mem     [DEPTH];

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [WDW-1:0]   watchdog;
  logic [TAG_W-1:0] job_tag;
  logic             push;
  logic             pop;

  // Ready comes from the registered count only, so a same-cycle pop never
  // opens a full FIFO.
  assign in_ready   = (count != FULL);
  assign push       = in_valid && in_ready;
  assign pop        = (state == S_IDLE) && (count != '0) && !set_busy;
  assign fifo_count = count;
  assign dbg_state  = state;

  // Write the incoming job into the tail slot
  always_ff @(posedge clk) begin
    if (push) begin
      central_mem[wr_ptr] <= in_central;
      radius_mem[wr_ptr]  <= in_radius;
      mode_mem[wr_ptr]    <= in_mode;
      tag_mem[wr_ptr]     <= in_tag;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Issue/wait/return sequencer with registered engine and host outputs.
  // Operands are loaded only when a job leaves the FIFO, so they stay put
  // while the engine re-reads them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      watchdog      <= '0;
      set_en        <= 1'b0;
      set_central   <= '0;
      set_radius    <= '0;
      set_mode      <= '0;
      job_tag       <= '0;
      out_valid     <= 1'b0;
      out_tag       <= '0;
      out_candidate <= '0;
      out_err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          set_en <= 1'b0;
          if (pop) begin
            set_central <= central_mem[rd_ptr];
            set_radius  <= radius_mem[rd_ptr];
            set_mode    <= mode_mem[rd_ptr];
            job_tag     <= tag_mem[rd_ptr];
            set_en      <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          set_en   <= 1'b0;
          watchdog <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          set_en <= 1'b0;
          if (set_valid) begin
            out_candidate <= set_candidate;
            out_err       <= 1'b0;
            out_valid     <= 1'b1;
            out_tag       <= job_tag;
            state         <= S_DONE;
          end else if (watchdog == WD_LAST) begin
            out_candidate <= '0;
            out_err       <= 1'b1;
            out_valid     <= 1'b1;
            out_tag       <= job_tag;
            state         <= S_DONE;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end
        S_DONE: begin
          set_en <= 1'b0;
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
